// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encodings and a
// count-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_e;

  // Bits needed to index v positions (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bor_in, one bit per clock LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERSUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bor_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH);

  ser_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             br;
  logic             accept, last, d_bit, br_nxt;

  assign accept = start_in && !busy;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  full_sub_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= last;
      if (accept) begin
        a_sh <= a_in;
        b_sh <= b_in;
        br   <= bor_in;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {d_bit, res_sh[WIDTH-1:1]};
        br     <= br_nxt;
        cnt    <= cnt + 1'b1;
        if (last) begin
          diff   <= {d_bit, res_sh[WIDTH-1:1]};
          borrow <= br_nxt;
          busy   <= 1'b0;
`ifdef SERSUB_OVF_EN
          // On the final bit the shift regs present the operand MSBs directly.
          ovf    <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
`endif
        end
      end
    end
  end

endmodule
